// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-select codes, RISC-V funct3 codes, dispatch FSM states
// and shift-unit operation codes.
package alu_pkg;

    typedef enum logic [2:0] {
        SEL_ADD_SUB = 3'b000,
        SEL_AND     = 3'b001,
        SEL_OR      = 3'b010,
        SEL_XOR     = 3'b011,
        SEL_SHIFT   = 3'b100
    } sel_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_op_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Shift functional unit with a start/done handshake. The default build shifts one bit per
// cycle; defining ALU_DISPATCH_FAST_SHIFT_EN builds a single-cycle barrel shifter instead.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  shift_op_e               op,
    input  logic [SIZE-1:0]         a,
    input  logic [$clog2(SIZE)-1:0] shamt,
    output logic                    done,
    output logic [SIZE-1:0]         result
);

`ifdef ALU_DISPATCH_FAST_SHIFT_EN

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        done = start;
        unique case (op)
            SH_SLL:  result = a << shamt;
            SH_SRL:  result = a >> shamt;
            SH_SRA:  result = $signed(a) >>> shamt;
            default: result = a;
        endcase
    end

`else

    localparam int CW = $clog2(SIZE);

    logic [SIZE-1:0] shreg;
    logic [SIZE-1:0] step;
    logic [CW-1:0]   cnt;
    shift_op_e       op_q;

    always_comb begin
        unique case (op_q)
            SH_SLL:  step = {shreg[SIZE-2:0], 1'b0};
            SH_SRL:  step = {1'b0, shreg[SIZE-1:1]};
            SH_SRA:  step = {shreg[SIZE-1], shreg[SIZE-1:1]};
            default: step = shreg;
        endcase
    end

    // A non-zero cnt is the busy flag; rst clearing it is what aborts a shift in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start && shamt != '0) begin
            cnt <= shamt;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // NOTE: shreg and op_q are don't-care while cnt is zero, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start && shamt != '0) begin
            shreg <= a;
            op_q  <= op;
        end else if (cnt != '0) begin
            shreg <= step;
        end
    end

    // Done fires combinationally on the last shifting edge so the caller captures step.
    assign done   = (start && shamt == '0) || (cnt == CW'(1));
    assign result = (cnt != '0) ? step : a;

`endif

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue front end: decodes one RISC-V integer op per handshake, steers it to the
// add/sub, logic or shift unit and holds the result until accepted. ALU_DISPATCH_FAST_SHIFT_EN
// selects the single-cycle shifter and drops the SHIFT state.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] result,
    output logic [2:0]      sel,
    output logic            err
);

    localparam int SHW = $clog2(SIZE);

    state_e          state;
    logic            is_shift;
    logic            dec_err;
    sel_e            dec_sel;
    shift_op_e       sh_op;
    logic [SIZE-1:0] alu_res;
    logic            sh_start;
    logic            sh_done;
    logic [SIZE-1:0] sh_res;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign sh_start = in_valid && in_ready && is_shift;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        is_shift = 1'b0;
        dec_err  = 1'b0;
        dec_sel  = SEL_ADD_SUB;
        sh_op    = SH_SLL;
        alu_res  = '0;
        case (funct3)
            F3_ADD_SUB: alu_res = funct7_b5 ? a - b : a + b;
            F3_AND: begin
                alu_res = a & b;
                dec_sel = SEL_AND;
            end
            F3_OR: begin
                alu_res = a | b;
                dec_sel = SEL_OR;
            end
            F3_XOR: begin
                alu_res = a ^ b;
                dec_sel = SEL_XOR;
            end
            F3_SLL: begin
                is_shift = 1'b1;
                dec_sel  = SEL_SHIFT;
            end
            F3_SRL_SRA: begin
                is_shift = 1'b1;
                dec_sel  = SEL_SHIFT;
                sh_op    = funct7_b5 ? SH_SRA : SH_SRL;
            end
            F3_SLT, F3_SLTU: dec_err = 1'b1;
        endcase
    end

    alu_shift_unit #(.SIZE(SIZE)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .start  (sh_start),
        .op     (sh_op),
        .a      (a),
        .shamt  (b[SHW-1:0]),
        .done   (sh_done),
        .result (sh_res)
    );

    // NOTE: all FSM state and registered outputs use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            sel       <= SEL_ADD_SUB;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sel <= dec_sel;
                        err <= dec_err;
                        if (is_shift && !sh_done) begin
                            state <= ST_SHIFT;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= is_shift ? sh_res : alu_res;
                        end
                    end
                end
`ifndef ALU_DISPATCH_FAST_SHIFT_EN
                ST_SHIFT: begin
                    if (sh_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= sh_res;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
